// File: rtl/wbs_mem.sv
// Wishbone B4 classic-cycle word memory responder with programmable wait states.
// Responds with a registered ack or err; a HOLD cycle absorbs the master's trailing strobe.
module wbs_mem #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               req_we_q, req_we_d;
  logic [3:0]         req_sel_q, req_sel_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;
  logic [31:0]        req_dat_q, req_dat_d;
  logic               req_err_q, req_err_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        rdat_q, rdat_d;

  logic [31:0]        mem [DEPTH];

  logic [31:0]        offset;
  logic               in_err;
  logic [IDX_W-1:0]   in_idx;

  logic               commit;
  logic               c_we;
  logic [3:0]         c_sel;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_dat;
  logic               c_err;
  logic               mem_we;

  // Decode the live request; BASE_ADDR is word aligned so offset[1:0] equals addr[1:0].
  always_comb begin
    offset = wbs_addr_i - BASE_ADDR;
    in_err = (offset[1:0] != 2'b00)
           || (wbs_addr_i < BASE_ADDR)
           || ({2'b00, offset[31:2]} >= DEPTH)
           || (wbs_sel_i == 4'b0000);
    in_idx = offset[IDX_W+1:2];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_we_d  = req_we_q;
    req_sel_d = req_sel_q;
    req_idx_d = req_idx_q;
    req_dat_d = req_dat_q;
    req_err_d = req_err_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdat_d    = rdat_q;
    commit    = 1'b0;
    c_we      = req_we_q;
    c_sel     = req_sel_q;
    c_idx     = req_idx_q;
    c_dat     = req_dat_q;
    c_err     = req_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          req_we_d  = wbs_we_i;
          req_sel_d = wbs_sel_i;
          req_idx_d = in_idx;
          req_dat_d = wbs_dat_i;
          req_err_d = in_err;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            // Zero wait states: commit straight from the bus in the acceptance cycle.
            state_d = S_RESP;
            commit  = 1'b1;
            c_we    = wbs_we_i;
            c_sel   = wbs_sel_i;
            c_idx   = in_idx;
            c_dat   = wbs_dat_i;
            c_err   = in_err;
          end
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        ack_d   = !req_err_q;
        err_d   = req_err_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (commit && !c_err && !c_we) begin
      rdat_d = mem[c_idx];
    end
    mem_we = commit && !c_err && c_we;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      req_we_q  <= 1'b0;
      req_sel_q <= 4'd0;
      req_idx_q <= '0;
      req_dat_q <= 32'h0;
      req_err_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdat_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_we_q  <= req_we_d;
      req_sel_q <= req_sel_d;
      req_idx_q <= req_idx_d;
      req_dat_q <= req_dat_d;
      req_err_q <= req_err_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdat_q    <= rdat_d;
    end
  end

  // Memory is never cleared; reset only suppresses a write that would land on the same edge.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel[b]) begin
          mem[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
        end
      end
    end
  end

  assign wbs_dat_o = rdat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;

endmodule

// File: tb/tb_wbs_mem.sv
// Testbench for wbs_mem: two instances (1 and 3 wait states) checked against a
// transaction-level memory model with directed and randomized Wishbone cycles.
module tb_wbs_mem;

  localparam int          W0 = 1;
  localparam int          W1 = 3;
  localparam int          D0 = 1024;
  localparam int          D1 = 256;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0000_1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdat0, rdat1;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mm [int];
  logic [31:0] exp_dat [2];

  always #5 clk_i = ~clk_i;

  wbs_mem #(.DEPTH(D0), .BASE_ADDR(B0), .WAIT_STATES(W0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
    .wbs_sel_i(sel[0]), .wbs_addr_i(addr[0]), .wbs_dat_i(wdat[0]),
    .wbs_dat_o(rdat0), .wbs_ack_o(ack0), .wbs_err_o(err0)
  );

  wbs_mem #(.DEPTH(D1), .BASE_ADDR(B1), .WAIT_STATES(W1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
    .wbs_sel_i(sel[1]), .wbs_addr_i(addr[1]), .wbs_dat_i(wdat[1]),
    .wbs_dat_o(rdat1), .wbs_ack_o(ack1), .wbs_err_o(err1)
  );

  function automatic int wst(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? B0 : B1;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? D0 : D1;
  endfunction

  function automatic logic obs_ack(input int d);
    return (d == 0) ? ack0 : ack1;
  endfunction

  function automatic logic obs_err(input int d);
    return (d == 0) ? err0 : err1;
  endfunction

  function automatic logic [31:0] obs_dat(input int d);
    return (d == 0) ? rdat0 : rdat1;
  endfunction

  // Error rule evaluated with wide arithmetic so no wrap can hide an out-of-range address.
  function automatic bit is_err(input int d, input logic [31:0] a, input logic [3:0] s);
    longint la, lb;
    la = longint'({32'b0, a});
    lb = longint'({32'b0, base_of(d)});
    if ((la % 4) != 0) return 1'b1;
    if (la < lb) return 1'b1;
    if (((la - lb) / 4) >= longint'(depth_of(d))) return 1'b1;
    if (s == 4'b0000) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int word_key(input int d, input logic [31:0] a);
    logic [31:0] w;
    w = (a - base_of(d)) >> 2;
    return d * 65536 + int'(w);
  endfunction

  function automatic logic [31:0] rand_addr(input int d);
    int unsigned r;
    logic [31:0] b;
    b = base_of(d);
    r = $urandom_range(0, 9);
    if (r <= 6) return b + 32'(4 * $urandom_range(0, 31));
    if (r == 7) return b + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
    if (r == 8) return b + 32'(depth_of(d) * 4) + 32'(4 * $urandom_range(0, 15));
    if (d == 1) return b - 32'(4 * $urandom_range(1, 8));
    return 32'hFFFF_FFFC;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full classic cycle; inputs are scrambled after acceptance to prove the request is latched.
  task automatic applyStimulus(input int d, input logic w, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] dt, input bit hold);
    bit          e;
    int          k;
    int          key;
    logic [31:0] v;
    bit          quiet;
    e = is_err(d, a, s);
    @(negedge clk_i);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdat[d] = dt;
    @(posedge clk_i); #1;
    we[d] = ~w; sel[d] = ~s; addr[d] = $urandom; wdat[d] = $urandom;
    k = 0;
    while (k < 20 && !obs_ack(d) && !obs_err(d)) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (!hold) begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
    end
    if (!e) begin
      key = word_key(d, a);
      if (w) begin
        v = mm.exists(key) ? mm[key] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = dt[8*b +: 8];
        mm[key] = v;
      end else begin
        exp_dat[d] = mm.exists(key) ? mm[key] : 32'h0;
      end
    end
    checkOutput("latency", 32'(k), 32'(wst(d) + 1));
    checkOutput("ack", 32'(obs_ack(d)), 32'(!e));
    checkOutput("err", 32'(obs_err(d)), 32'(e));
    checkOutput("dat_o", obs_dat(d), exp_dat[d]);
    @(posedge clk_i); #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    checkOutput("single_cycle", 32'({obs_ack(d), obs_err(d)}), 32'd0);
    quiet = 1'b1;
    repeat (wst(d) + 3) begin
      @(posedge clk_i); #1;
      if (obs_ack(d) || obs_err(d)) quiet = 1'b0;
    end
    checkOutput("no_extra_resp", 32'(quiet), 32'd1);
  endtask

  task automatic abortWrite(input int d, input logic [31:0] a, input logic [31:0] dt);
    bit quiet;
    @(negedge clk_i);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; sel[d] = 4'hF; addr[d] = a; wdat[d] = dt;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(posedge clk_i); #1;
      if (obs_ack(d) || obs_err(d)) quiet = 1'b0;
    end
    checkOutput("abort_quiet", 32'(quiet), 32'd1);
    checkOutput("abort_dat", obs_dat(d), exp_dat[d]);
  endtask

  task automatic resetInWait(input int d, input logic [31:0] a, input logic [31:0] dt);
    bit quiet;
    @(negedge clk_i);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; sel[d] = 4'hF; addr[d] = a; wdat[d] = dt;
    @(posedge clk_i); #1;
    rst_i = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_dat[0] = 32'h0;
    exp_dat[1] = 32'h0;
    quiet = !(obs_ack(d) || obs_err(d));
    checkOutput("rst_wait_dat0", rdat0, 32'h0);
    checkOutput("rst_wait_dat1", rdat1, 32'h0);
    checkOutput("rst_wait_quiet", 32'(quiet), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0;
      addr[d] = 32'h0; wdat[d] = 32'h0; exp_dat[d] = 32'h0;
    end
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_ack0", 32'(ack0), 32'd0);
    checkOutput("rst_err0", 32'(err0), 32'd0);
    checkOutput("rst_dat0", rdat0, 32'h0);
    checkOutput("rst_ack1", 32'(ack1), 32'd0);
    checkOutput("rst_err1", 32'(err1), 32'd0);
    checkOutput("rst_dat1", rdat1, 32'h0);
    rst_i = 1'b0;

    // Basic write/read, byte-lane merge, then error terminations that must leave state alone.
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    checkOutput("read_0x10", rdat0, 32'hDEADBEEF);
    applyStimulus(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0);
    applyStimulus(0, 1'b1, 4'b0100, 32'h20, 32'h00AA0000, 1'b0);
    applyStimulus(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
    checkOutput("read_0x20_merge", rdat0, 32'h11AA3344);
    applyStimulus(0, 1'b0, 4'hF, 32'h13, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 4'hF, 32'(D0 * 4), 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b0);
    checkOutput("err_dat_hold", rdat0, 32'h11AA3344);
    applyStimulus(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
    checkOutput("err_mem_hold", rdat0, 32'h11AA3344);
    applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);

    // Give every word in the random window a known value.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) begin
        applyStimulus(d, 1'b1, 4'hF, base_of(d) + 32'(4 * i), $urandom, 1'b0);
      end
    end

    abortWrite(1, B1 + 32'h40, 32'hCAFEF00D);
    applyStimulus(1, 1'b0, 4'hF, B1 + 32'h40, 32'h0, 1'b0);

    resetInWait(1, B1 + 32'h50, 32'h55AA55AA);
    applyStimulus(1, 1'b0, 4'hF, B1 + 32'h50, 32'h0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int d;
      d = n % 2;
      applyStimulus(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(d),
                    $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
